// File: rtl/modbus_rtu_frame_receiver.sv
// Modbus RTU frame receiver: drains the UART byte FIFO, frames on 3.5-char silence,
// checks CRC-16/MODBUS and address, and holds the frame. Option: MODBUS_RX_BROADCAST_EN.
module modbus_rtu_frame_receiver #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SLAVE_ADDR   = 8'h01,
  parameter int unsigned MAX_FRAME    = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_ready,
  output logic       o_rx_rden,
  input  logic [4:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  output logic       o_frame_valid,
  output logic [5:0] o_frame_len,
  output logic       o_broadcast,
  input  logic       i_frame_ack,
  output logic       o_crc_err,
  output logic [7:0] o_err_count
);

  localparam int unsigned T35 = (77 * CLKS_PER_BIT) / 2;
  localparam int unsigned TW  = $clog2(T35 + 1);
  localparam int unsigned LW  = 7;
  localparam int unsigned AW  = (MAX_FRAME > 1) ? $clog2(MAX_FRAME) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(T35 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   crc_q, crc_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rden_q;
  logic          frame_valid_q, frame_valid_d;
  logic [5:0]    frame_len_q, frame_len_d;
  logic          bcast_q, bcast_d;
  logic          crc_err_q, crc_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [7:0]    mem_q [MAX_FRAME];
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic          pop;
  logic          addr_bcast;
  logic          addr_ok;

  // One reflected-polynomial CRC step per byte, all 8 bit iterations unrolled.
  function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  // Pop at most every other cycle; CHECK leaves the next byte queued for the next frame.
  assign pop       = i_rx_ready & i_enable & ~rden_q & ~i_rst & (state_q != S_CHECK);
  assign o_rx_rden = pop;

`ifdef MODBUS_RX_BROADCAST_EN
  assign addr_bcast = (mem_q[0] == 8'h00);
`else
  assign addr_bcast = 1'b0;
`endif
  assign addr_ok = (mem_q[0] == SLAVE_ADDR) | addr_bcast;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    crc_d     = crc_q;
    crc_err_d = 1'b0;
    err_cnt_d = err_cnt_q;
    mem_we    = 1'b0;
    mem_widx  = '0;
    timer_d   = pop ? '0 : ((timer_q == T_LAST) ? timer_q : timer_q + TW'(1));
    case (state_q)
      S_IDLE: begin
        len_d = '0;
        ovf_d = 1'b0;
        crc_d = 16'hFFFF;
        if (pop) begin
          mem_we  = 1'b1;
          len_d   = LW'(1);
          crc_d   = crc_byte(16'hFFFF, i_rx_data);
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (pop) begin
          crc_d = crc_byte(crc_q, i_rx_data);
          if (len_q < LW'(MAX_FRAME)) begin
            mem_we   = 1'b1;
            mem_widx = AW'(len_q);
            len_d    = len_q + LW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else if (timer_d == T_LAST) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (ovf_q || (len_q < LW'(4)) || (crc_q != 16'h0000)) begin
          crc_err_d = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          state_d = S_IDLE;
        end else if (addr_ok) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (i_frame_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Disable abandons whatever is in flight, including a pending rejection.
    if (!i_enable) begin
      state_d   = S_IDLE;
      crc_err_d = 1'b0;
      err_cnt_d = err_cnt_q;
    end
    frame_valid_d = (state_d == S_HOLD);
    frame_len_d   = frame_valid_d ? 6'(len_q - LW'(2)) : 6'd0;
    bcast_d       = frame_valid_d & addr_bcast;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      ovf_q         <= 1'b0;
      crc_q         <= 16'hFFFF;
      timer_q       <= '0;
      rden_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= '0;
      bcast_q       <= 1'b0;
      crc_err_q     <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      ovf_q         <= ovf_d;
      crc_q         <= crc_d;
      timer_q       <= timer_d;
      rden_q        <= pop;
      frame_valid_q <= frame_valid_d;
      frame_len_q   <= frame_len_d;
      bcast_q       <= bcast_d;
      crc_err_q     <= crc_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  // Frame buffer keeps its contents across reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[mem_widx] <= i_rx_data;
  end

  always_comb begin
    o_rd_data = 8'h00;
    if (LW'(i_rd_addr) < LW'(MAX_FRAME)) o_rd_data = mem_q[AW'(i_rd_addr)];
  end

  assign o_frame_valid = frame_valid_q;
  assign o_frame_len   = frame_len_q;
  assign o_broadcast   = bcast_q;
  assign o_crc_err     = crc_err_q;
  assign o_err_count   = err_cnt_q;

endmodule
